// File: rtl/failure_table_pkg.sv
// Shared Aho-Corasick definitions: automaton sizing defaults and the
// failure-table controller state encoding.
package failure_table_pkg;

  localparam int AC_STATE_W = 8;
  localparam int AC_DEPTH   = 32;

  localparam logic [1:0] FT_CLEAR = 2'd0;
  localparam logic [1:0] FT_RUN   = 2'd1;
  localparam logic [1:0] FT_DRAIN = 2'd2;

  // Index width for a table of the given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/failure_rsp_fifo.sv
// Two-entry in-order response buffer; output data reads as zero while empty.
module failure_rsp_fifo #(
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && (r_count != 2'd2);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/failure_table.sv
// Aho-Corasick failure-link table: swept clear, write-first single-cycle
// lookup, and a two-deep response buffer for backpressure.
module failure_table
  import failure_table_pkg::*;
#(
  parameter int  STATE_W = AC_STATE_W,
  parameter int  DEPTH   = AC_DEPTH,
  localparam int ADDR_W  = addr_w(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clr,
  output logic               busy,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [STATE_W-1:0] wr_data,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [STATE_W-1:0] rsp_state,
  output logic               rsp_hit,
  output logic               rsp_err
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_sweep;
  logic [STATE_W-1:0] r_mem [DEPTH];
  logic               r_vld [DEPTH];

  logic               w_req_fire;
  logic               w_req_oor;
  logic               w_wr_ok;
  logic [STATE_W-1:0] w_rd_state;
  logic               w_rd_hit;
  logic               w_rd_err;
  logic [1:0]         w_fifo_count;
  logic [STATE_W+1:0] w_fifo_out;

  assign w_req_oor  = ({1'b0, req_addr} >= DEPTH_L);
  assign w_wr_ok    = wr_en && (r_state == FT_RUN) && ({1'b0, wr_addr} < DEPTH_L);
  assign req_ready  = (r_state == FT_RUN) && (w_fifo_count < 2'd2);
  assign w_req_fire = req_valid && req_ready;
  assign busy       = (r_state != FT_RUN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= FT_CLEAR;
      r_sweep <= '0;
    end else begin
      case (r_state)
        FT_CLEAR: begin
          if (r_sweep == LAST_L) begin
            r_sweep <= '0;
            r_state <= FT_RUN;
          end else begin
            r_sweep <= r_sweep + ADDR_W'(1);
          end
        end
        FT_RUN:   if (clr) r_state <= FT_DRAIN;
        // Lookups are pushed straight into the buffer, so an empty buffer means nothing is in flight.
        FT_DRAIN: if (w_fifo_count == 2'd0) r_state <= FT_CLEAR;
        default:  r_state <= FT_CLEAR;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == FT_CLEAR) begin
      r_mem[r_sweep] <= '0;
      r_vld[r_sweep] <= 1'b0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
      r_vld[wr_addr] <= 1'b1;
    end
  end

  // Same-cycle write to the looked-up entry wins over the stored copy.
  always_comb begin
    w_rd_state = '0;
    w_rd_hit   = 1'b0;
    w_rd_err   = 1'b0;
    if (w_req_oor) begin
      w_rd_err = 1'b1;
    end else if (w_wr_ok && (wr_addr == req_addr)) begin
      w_rd_state = wr_data;
      w_rd_hit   = 1'b1;
    end else begin
      w_rd_state = r_mem[req_addr];
      w_rd_hit   = r_vld[req_addr];
    end
  end

  failure_rsp_fifo #(
    .WIDTH(STATE_W + 2)
  ) u_rsp_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .i_push (w_req_fire),
    .i_data ({w_rd_state, w_rd_hit, w_rd_err}),
    .i_pop  (rsp_ready),
    .o_valid(rsp_valid),
    .o_data (w_fifo_out),
    .o_count(w_fifo_count)
  );

  assign rsp_state = w_fifo_out[STATE_W+1:2];
  assign rsp_hit   = w_fifo_out[1];
  assign rsp_err   = w_fifo_out[0];

endmodule

// File: tb/tb_failure_table.sv
// Directed bench for failure_table: vector table plus multi-cycle sequences.
module tb_failure_table;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, clr, wr_en, req_valid, rsp_ready;
  logic [4:0] wr_addr, req_addr;
  logic [7:0] wr_data;
  logic       busy, req_ready, rsp_valid, rsp_hit, rsp_err;
  logic [7:0] rsp_state;
  logic       d2_busy, d2_req_ready, d2_rsp_valid, d2_rsp_hit, d2_rsp_err;
  logic [7:0] d2_rsp_state;

  int total = 0;
  int bad   = 0;

  failure_table dut (
    .CLK(CLK), .RST(RST), .clr(clr), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err)
  );

  // Non-power-of-two depth so that out-of-range addresses are representable.
  failure_table #(.STATE_W(8), .DEPTH(24)) dut2 (
    .CLK(CLK), .RST(RST), .clr(clr), .busy(d2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(d2_req_ready), .req_addr(req_addr),
    .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_state(d2_rsp_state),
    .rsp_hit(d2_rsp_hit), .rsp_err(d2_rsp_err)
  );

  typedef struct {
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       req_valid;
    logic [4:0] req_addr;
    logic       e_valid;
    logic [7:0] e_state;
    logic       e_hit;
    logic       e_err;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] got[4];
  int         n, nb, si;
  logic       fire;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;

    //         wr  waddr  wdata  rq  raddr  v  state  hit err
    vecs[0]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd5,  1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd3,  8'h07, 1'b0, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd3,  1'b1, 8'h07, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'd9,  8'h11, 1'b1, 5'd9,  1'b1, 8'h11, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd20, 8'h3C, 1'b1, 5'd3,  1'b1, 8'h07, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd20, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd31, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd31, 8'hFF, 1'b1, 5'd0,  1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd31, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 5'd0,  8'h01, 1'b1, 5'd0,  1'b1, 8'h01, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 5'd3,  8'h44, 1'b1, 5'd3,  1'b1, 8'h44, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd9,  1'b1, 8'h11, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_state", rsp_state, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // Clear sweep after release lasts DEPTH cycles
    RST = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      n++;
      step();
    end
    chk("clear_len", n, 32);
    chk("ready_after_clear", req_ready, 1);

    // Vector table, one lookup per cycle with rsp_ready high
    for (int i = 0; i < 12; i++) begin
      wr_en     = vecs[i].wr_en;
      wr_addr   = vecs[i].wr_addr;
      wr_data   = vecs[i].wr_data;
      req_valid = vecs[i].req_valid;
      req_addr  = vecs[i].req_addr;
      step();
      wr_en     = 1'b0;
      req_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), rsp_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_state", i), rsp_state, vecs[i].e_state);
        chk($sformatf("vec%0d_hit", i), rsp_hit, vecs[i].e_hit);
        chk($sformatf("vec%0d_err", i), rsp_err, vecs[i].e_err);
      end
    end

    // Out-of-range lookups on the 24-entry instance
    chk("d2_running", d2_busy, 0);
    chk("d2_ready", d2_req_ready, 1);
    req_valid = 1'b1; req_addr = 5'd24;
    step();
    req_valid = 1'b0;
    chk("oor24_valid", d2_rsp_valid, 1);
    chk("oor24_err", d2_rsp_err, 1);
    chk("oor24_state", d2_rsp_state, 0);
    chk("oor24_hit", d2_rsp_hit, 0);
    chk("inrange24_err_main", rsp_err, 0);
    req_valid = 1'b1; req_addr = 5'd23;
    step();
    req_valid = 1'b0;
    chk("inrange23_err", d2_rsp_err, 0);

    // Backpressure: program 1..4, then lookups with rsp_ready low for 3 cycles
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 8'(8'h20 + i);
      step();
    end
    wr_en = 1'b0;
    si = 0; n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      rsp_ready = (c >= 3);
      req_valid = (si < 4);
      req_addr  = 5'(si + 1);
      if (c == 2) begin
        chk("bp_ready_drop", req_ready, 0);
        chk("bp_hold_state", rsp_state, 8'h21);
      end
      if (rsp_valid && rsp_ready) begin
        chk($sformatf("bp_hit%0d", n), rsp_hit, 1);
        got[n] = rsp_state;
        n++;
      end
      fire = req_valid && req_ready;
      step();
      if (fire) si++;
    end
    req_valid = 1'b0;
    chk("bp_count", n, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("bp_order%0d", k), got[k], 8'h21 + k);
    chk("bp_no_dup", rsp_valid, 0);

    // clr with two pending responses
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 5'd3;
    step();
    req_addr = 5'd4;
    step();
    req_valid = 1'b0;
    chk("clr_pending_full", req_ready, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy", busy, 1);
    rsp_ready = 1'b1;
    n = 0; nb = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      if (rsp_valid) begin
        if (n < 4) got[n] = rsp_state;
        n++;
      end else begin
        nb++;
      end
      clr = (k == 10);
      step();
    end
    clr = 1'b0;
    chk("clr_drained", n, 2);
    chk("clr_first", got[0], 8'h23);
    chk("clr_second", got[1], 8'h24);
    // One idle DRAIN cycle once empty, then the 32-cycle sweep.
    chk("clr_busy_len", nb, 33);
    chk("clr_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = 5'd3;
    step();
    req_valid = 1'b0;
    chk("post_clr_valid", rsp_valid, 1);
    chk("post_clr_hit", rsp_hit, 0);
    chk("post_clr_state", rsp_state, 0);

    // Reset in the middle of a lookup
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 5'd9;
    step();
    req_valid = 1'b0;
    chk("mid_rst_pending", rsp_valid, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_state", rsp_state, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      n++;
      step();
    end
    chk("mid_rst_clear_len", n, 32);
    chk("mid_rst_no_rsp", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
